// File: rtl/cntr_prog.sv
// Programmable up/down counter with prescaler, limit, compare and wrap/saturate/one-shot boundary modes.
// Latency: every output is registered and updates one clock after the cause; there is no backpressure.
module cntr_prog #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [PRE_W-1:0] prescale_i,
    input  logic [WIDTH-1:0] cmp_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             wrap_o,
    output logic             match_o,
    output logic             done_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = '0;
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_tick;
    logic             r_wrap;
    logic             r_match;
    logic             w_tick_nxt;
    logic             w_wrap_nxt;
    logic             w_match_nxt;

    logic             w_mode_sat;
    logic             w_mode_oneshot;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_wrap;
    logic             w_step_halt;
    logic             w_pre_hit;

    assign w_mode_sat     = (mode_i == 2'b01);
    assign w_mode_oneshot = (mode_i == 2'b10);
    assign w_load_val     = (load_val_i > limit_i) ? limit_i : load_val_i;
    // >= rather than == so that lowering prescale_i below pre_cnt still steps next cycle
    assign w_pre_hit      = (r_pre_cnt >= prescale_i);

    // Value the counter would take if a step happened this cycle.
    always_comb begin
        w_step_val  = r_count;
        w_step_wrap = 1'b0;
        w_step_halt = 1'b0;
        if (dir_i) begin
            if (r_count < limit_i) begin
                w_step_val = r_count + CNT_ONE;
            end else begin
                w_step_wrap = 1'b1;
                if (w_mode_sat) begin
                    w_step_val = limit_i;
                end else if (w_mode_oneshot) begin
                    w_step_halt = 1'b1;
                end else begin
                    w_step_val = CNT_ZERO;
                end
            end
        end else begin
            if (r_count > limit_i) begin
                w_step_val  = limit_i;
                w_step_wrap = 1'b1;
            end else if (r_count == CNT_ZERO) begin
                w_step_wrap = 1'b1;
                if (w_mode_oneshot) begin
                    w_step_halt = 1'b1;
                end else if (!w_mode_sat) begin
                    w_step_val = limit_i;
                end
            end else begin
                w_step_val = r_count - CNT_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre_cnt;
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_match_nxt = 1'b0;
        if (load_i) begin
            w_state_nxt = ST_RUN;
            w_pre_nxt   = PRE_ZERO;
            w_count_nxt = w_load_val;
            w_match_nxt = (w_load_val == cmp_i);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (en_i) begin
                        if (w_pre_hit) begin
                            w_pre_nxt   = PRE_ZERO;
                            w_count_nxt = w_step_val;
                            w_tick_nxt  = 1'b1;
                            w_wrap_nxt  = w_step_wrap;
                            w_match_nxt = (w_step_val == cmp_i);
                            if (w_step_halt) begin
                                w_state_nxt = ST_HALT;
                            end
                        end else begin
                            w_pre_nxt = r_pre_cnt + PRE_ONE;
                        end
                    end
                end
                ST_HALT: begin
                    w_state_nxt = ST_HALT;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_RUN;
            r_pre_cnt <= PRE_ZERO;
            r_count   <= CNT_ZERO;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_pre_nxt;
            r_count   <= w_count_nxt;
            r_tick    <= w_tick_nxt;
            r_wrap    <= w_wrap_nxt;
            r_match   <= w_match_nxt;
        end
    end

    assign count_o = r_count;
    assign tick_o  = r_tick;
    assign wrap_o  = r_wrap;
    assign match_o = r_match;
    assign done_o  = (r_state == ST_HALT);

endmodule

// File: doc/cntr_prog.md
CNTR_PROG -- requirements
Module: cntr_prog

Interface
REQ-001: Parameter WIDTH, default 16, counter and value width in bits (legal range 2..32).
REQ-002: Parameter PRE_W, default 8, prescaler width in bits.
REQ-003: wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004: wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005: en_i  input  1  count enable; when low, the prescaler and counter hold.
REQ-006: dir_i  input  1  direction: 1 counts up, 0 counts down.
REQ-007: mode_i  input  2  boundary mode: 00 wrap, 01 saturate, 10 one-shot; 11 behaves as 00.
REQ-008: load_i  input  1  synchronous load strobe.
REQ-009: load_val_i  input  WIDTH  value to load.
REQ-010: limit_i  input  WIDTH  upper bound of the count range [0, limit_i].
REQ-011: prescale_i  input  PRE_W  divider; the counter steps once every prescale_i+1 enabled cycles.
REQ-012: cmp_i  input  WIDTH  compare value.
REQ-013: count_o  output  WIDTH  registered current count.
REQ-014: tick_o  output  1  one-cycle pulse, high in the cycle count_o shows a stepped value.
REQ-015: wrap_o  output  1  one-cycle pulse on any step taken at a boundary.
REQ-016: match_o  output  1  one-cycle pulse, high in the first cycle count_o equals cmp_i after a step or load.
REQ-017: done_o  output  1  level; high while the one-shot counter is halted.

Function
REQ-018: Internal states are RUN and HALT; reset enters RUN.
REQ-019: Prescaler pre_cnt increments on each cycle with en_i=1 in RUN; when pre_cnt==prescale_i, a step occurs and pre_cnt returns to 0.
REQ-020: prescale_i=0 steps on every enabled cycle.
REQ-021: If prescale_i is lowered below the current pre_cnt, the prescaler steps on the next enabled cycle and returns to 0.
REQ-022: Up step with count_o < limit_i: count_o+1.
REQ-023: Up step with count_o >= limit_i: wrap mode loads 0; saturate mode loads limit_i; one-shot mode holds count_o and enters HALT; wrap_o pulses in all three cases.
REQ-024: Down step with count_o > 0 and count_o <= limit_i: count_o-1.
REQ-025: Down step with count_o == 0: wrap mode loads limit_i; saturate mode holds 0; one-shot mode holds and enters HALT; wrap_o pulses in all three cases.
REQ-026: Down step with count_o > limit_i loads limit_i and pulses wrap_o.
REQ-027: tick_o pulses on every step, including saturate holds and the step that enters HALT.
REQ-028: load_i has priority over a same-cycle step: count_o <= min(load_val_i, limit_i), pre_cnt <= 0, state <= RUN, done_o cleared, no tick_o/wrap_o.
REQ-029: Load is accepted regardless of en_i and in both states.
REQ-030: match_o pulses when a step or load produces next count == cmp_i, including when the value is unchanged (saturate hold, load of equal value).
REQ-031: In HALT, the prescaler and count hold and no pulses occur; only load_i or reset leaves HALT.
REQ-032: done_o = (state==HALT), registered, rising in the same cycle as the terminal wrap_o.
REQ-033: Changing mode_i takes effect at the next step; it does not leave HALT.
REQ-034: All outputs are registered, with no combinational path from inputs to outputs.

Reset
REQ-035: wb_rst_i high at a clock edge sets count_o=0, pre_cnt=0, tick_o=wrap_o=match_o=0, done_o=0, state RUN.
REQ-036: Reset overrides load_i and steps in the same cycle; mid-count reset loses all progress.

Verification (WIDTH=8)
REQ-037: Wrap up: limit=5, prescale=0, dir=1, mode=00, en=1 from 0 -> count 1,2,3,4,5,0; wrap_o with 0; tick_o every cycle.
REQ-038: Prescale/saturate down: load 3, prescale=2, dir=0, mode=01 -> count 2,1,0 every third cycle, then 0 held; wrap_o and tick_o on each further step.
REQ-039: One-shot: load 254, limit=255, dir=1, mode=10 -> 255 then HALT; done_o=1, wrap_o one pulse, count frozen; load 7 -> count 7, done_o=0.
REQ-040: Compare: cmp=3, up from 0, limit=9 -> match_o single pulse when count_o=3; load_i of 3 -> match_o again.
REQ-041: Collisions: load_i coincident with a step -> load value wins, no tick_o; reset coincident with load_i -> count 0.
REQ-042: Limit change: count=9, limit set to 4, up step -> 0 and wrap_o (wrap mode); down step -> 4 and wrap_o.
